// File: rtl/mavg_capture_ctrl.sv
// -----------------------------------------------------------------------------
// mavg_capture_ctrl
//
// Sequencing controller for the ADC moving-average decimator. A software start
// latches a new averaging factor and frame length, holds the filter in reset
// for two cycles so that no partial sum built with the old factor leaks out,
// optionally waits for a trigger rising edge, then packetizes frame_len filter
// outputs into an AXI4-Stream frame terminated by tlast.
//
// Build option:
//   MAVG_CTRL_TRIG_EN  when defined, adds the trig_in port and the ARMED state;
//                      capture then starts on a trig_in rising edge. When
//                      undefined, FLUSH proceeds directly to CAPTURE.
//
// Ports:
//   clk              sole clock
//   rst              asynchronous, active-low reset
//   cfg_start        one-cycle start pulse (ignored outside IDLE or with stop)
//   cfg_stop         one-cycle stop pulse
//   cfg_mavg_factor  requested averaging factor
//   cfg_frame_len    samples per frame (0 makes start a no-op)
//   trig_in          external trigger (MAVG_CTRL_TRIG_EN only)
//   mavg_factor_out  factor driven to the filter, changes only on start
//   filt_rst_n       active-low synchronous reset to the filter
//   filt_valid       filter output strobe
//   filt_data        filter output sample
//   m_axis_*         AXI4-Stream master (tdata, tvalid, tready, tlast)
//   busy             high in any state other than IDLE
//   done             one-cycle pulse after the tlast handshake
//   overrun_cnt      saturating count of samples dropped under backpressure
// -----------------------------------------------------------------------------
module mavg_capture_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [31:0]           cfg_mavg_factor,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
`ifdef MAVG_CTRL_TRIG_EN
    input  logic                  trig_in,
`endif
    output logic [31:0]           mavg_factor_out,
    output logic                  filt_rst_n,
    input  logic                  filt_valid,
    input  logic [DATA_WIDTH-1:0] filt_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           overrun_cnt
);

    // ARMED keeps its encoding reserved even when the trigger is not built.
`ifdef MAVG_CTRL_TRIG_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;
`endif

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  state_n_s;
    logic                    flush_cnt_r;
    logic [LEN_WIDTH-1:0]    frame_len_r;
    logic [LEN_WIDTH-1:0]    cnt_r;
    logic                    stop_pend_r;
    logic [31:0]             mavg_factor_r;
    logic [DATA_WIDTH-1:0]   tdata_r;
    logic                    tvalid_r;
    logic                    tlast_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    filt_rst_n_r;
    logic [15:0]             overrun_r;
`ifdef MAVG_CTRL_TRIG_EN
    logic                    trig_d_r;
`endif

    logic                    start_ok_s;
    logic                    in_capture_s;
    logic                    handshake_s;
    logic                    last_pend_s;
    logic                    reg_free_s;
    logic                    stop_now_s;
    logic                    accept_s;
    logic                    drop_s;
    logic                    new_last_s;

    // Capture-path qualifiers: acceptance, drops and the tlast decision.
    always_comb begin
        start_ok_s   = 1'b0;
        in_capture_s = 1'b0;
        handshake_s  = 1'b0;
        last_pend_s  = 1'b0;
        reg_free_s   = 1'b0;
        stop_now_s   = 1'b0;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        new_last_s   = 1'b0;

        if ((state_r == ST_IDLE) && cfg_start && !cfg_stop && (cfg_frame_len != LEN_ZERO)) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end

        in_capture_s = (state_r == ST_CAPTURE);
        handshake_s  = tvalid_r && m_axis_tready;
        // Once the tlast beat sits in the output register the frame is full:
        // no further samples are taken and a late stop has nothing to do.
        last_pend_s  = tvalid_r && tlast_r;
        reg_free_s   = !tvalid_r || m_axis_tready;

        if (in_capture_s) begin
            stop_now_s = cfg_stop && !last_pend_s;
            accept_s   = filt_valid && reg_free_s && !last_pend_s;
            drop_s     = filt_valid && !reg_free_s;
        end else begin
            stop_now_s = 1'b0;
            accept_s   = 1'b0;
            drop_s     = 1'b0;
        end

        // A stop seen in this same cycle already shortens the frame.
        new_last_s = (cnt_r == (frame_len_r - LEN_ONE)) || stop_pend_r || stop_now_s;
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_n_s = ST_FLUSH;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cfg_stop) begin
                    state_n_s = ST_IDLE;
                end else if (flush_cnt_r) begin
`ifdef MAVG_CTRL_TRIG_EN
                    state_n_s = ST_ARMED;
`else
                    state_n_s = ST_CAPTURE;
`endif
                end else begin
                    state_n_s = ST_FLUSH;
                end
            end
`ifdef MAVG_CTRL_TRIG_EN
            ST_ARMED: begin
                if (cfg_stop) begin
                    state_n_s = ST_IDLE;
                end else if (trig_in && !trig_d_r) begin
                    state_n_s = ST_CAPTURE;
                end else begin
                    state_n_s = ST_ARMED;
                end
            end
`endif
            ST_CAPTURE: begin
                if (handshake_s && tlast_r) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            filt_rst_n_r <= 1'b0;
            flush_cnt_r  <= 1'b0;
        end else begin
            busy_r       <= (state_n_s != ST_IDLE);
            done_r       <= (state_n_s == ST_DONE);
            filt_rst_n_r <= (state_n_s != ST_FLUSH);
            flush_cnt_r  <= (state_r == ST_FLUSH);
        end
    end

`ifdef MAVG_CTRL_TRIG_EN
    // Previous trig_in value for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_d_r <= 1'b0;
        end else begin
            trig_d_r <= trig_in;
        end
    end
`endif

    // Configuration latch, frame counter, overrun counter and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_len_r   <= LEN_ZERO;
            cnt_r         <= LEN_ZERO;
            stop_pend_r   <= 1'b0;
            mavg_factor_r <= 32'd0;
            tdata_r       <= {DATA_WIDTH{1'b0}};
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            overrun_r     <= 16'd0;
        end else if (start_ok_s) begin
            frame_len_r   <= cfg_frame_len;
            mavg_factor_r <= cfg_mavg_factor;
            cnt_r         <= LEN_ZERO;
            stop_pend_r   <= 1'b0;
            tlast_r       <= 1'b0;
            overrun_r     <= 16'd0;
        end else if (in_capture_s) begin
            if (stop_now_s) begin
                stop_pend_r <= 1'b1;
            end
            if (accept_s) begin
                tdata_r  <= filt_data;
                tlast_r  <= new_last_s;
                tvalid_r <= 1'b1;
                cnt_r    <= cnt_r + LEN_ONE;
            end else if (handshake_s) begin
                tvalid_r <= 1'b0;
            end
            if (drop_s && (overrun_r != 16'hFFFF)) begin
                overrun_r <= overrun_r + 16'd1;
            end
        end
    end

    assign mavg_factor_out = mavg_factor_r;
    assign filt_rst_n      = filt_rst_n_r;
    assign m_axis_tdata    = tdata_r;
    assign m_axis_tvalid   = tvalid_r;
    assign m_axis_tlast    = tlast_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign overrun_cnt     = overrun_r;

endmodule

// File: tb/tb_mavg_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mavg_capture_ctrl
//
// Bench for mavg_capture_ctrl (default build, trigger disabled). A cycle-level
// behavioural model of the capture sequence predicts every output each cycle.
// Frames are described by a table of records with hand-derived beat counts and
// overrun totals; hand sequences cover start corner cases and reset mid-frame;
// randomized frames finish the run.
// -----------------------------------------------------------------------------
module tb_mavg_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [31:0] fac;
    logic [15:0] len;
    logic        trig;
    logic        fv;
    logic [15:0] fd;
    logic        rdy;
    logic [31:0] mavg_factor_out;
    logic        filt_rst_n;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, busy, done;
    logic [15:0] overrun_cnt;

    always #5 clk = ~clk;

    mavg_capture_ctrl #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (start),
        .cfg_stop        (stop),
        .cfg_mavg_factor (fac),
        .cfg_frame_len   (len),
`ifdef MAVG_CTRL_TRIG_EN
        .trig_in         (trig),
`endif
        .mavg_factor_out (mavg_factor_out),
        .filt_rst_n      (filt_rst_n),
        .filt_valid      (fv),
        .filt_data       (fd),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (rdy),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .done            (done),
        .overrun_cnt     (overrun_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int hs_cnt = 0;

    // Reference model: phase 0 idle, 1 flush, 2 capture, 3 done.
    int          m_phase, m_flush_left, m_len, m_cnt, m_ovr;
    bit          m_stop, m_v, m_l, m_done, m_busy, m_frst;
    logic [15:0] m_d;
    logic [31:0] m_fac;

    typedef struct {
        logic [31:0] fac;
        int len;
        int gap;        // filt_valid every gap cycles from the first capture cycle
        int rdy_low;    // tready low for this many capture cycles
        int stop_t;     // cycle of a stop pulse (-1 none), cycle 0 = start
        int start2_t;   // cycle of an extra start pulse (-1 none)
        int exp_beats;
        int exp_ovr;
    } frame_t;

    frame_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_flush_left = 0; m_len = 0; m_cnt = 0; m_ovr = 0;
        m_stop = 1'b0; m_v = 1'b0; m_l = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        m_frst = 1'b0; m_d = 16'd0; m_fac = 32'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit hs, free, lastp;
        hs = m_v && rdy;
        case (m_phase)
            0: if (start && !stop && len != 16'd0) begin
                m_fac = fac; m_len = int'(len); m_cnt = 0; m_ovr = 0;
                m_stop = 1'b0; m_l = 1'b0; m_phase = 1; m_flush_left = 2;
            end
            1: if (stop) m_phase = 0;
               else begin
                   m_flush_left--;
                   if (m_flush_left == 0) m_phase = 2;
               end
            2: begin
                lastp = m_v && m_l;
                free  = !m_v || rdy;
                if (stop && !lastp) m_stop = 1'b1;
                if (hs && m_l) begin
                    m_v = 1'b0; m_phase = 3;
                end else if (fv && free) begin
                    m_d = fd; m_l = (m_cnt == m_len - 1) || m_stop; m_cnt++; m_v = 1'b1;
                end else if (hs) begin
                    m_v = 1'b0;
                end
                if (fv && !free && m_ovr < 65535) m_ovr++;
            end
            3: m_phase = 0;
            default: m_phase = 0;
        endcase
        m_busy = (m_phase != 0);
        m_done = (m_phase == 3);
        m_frst = (m_phase != 1);
    endtask

    task automatic compare_all();
        chk("tvalid", 32'(m_axis_tvalid), 32'(m_v));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("filt_rst_n", 32'(filt_rst_n), 32'(m_frst));
        chk("mavg_factor_out", mavg_factor_out, m_fac);
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
        if (m_v) begin
            chk("tdata", 32'(m_axis_tdata), 32'(m_d));
            chk("tlast", 32'(m_axis_tlast), 32'(m_l));
        end
    endtask

    // One clock: model step, edge, then compare 1 time unit later.
    task automatic cyc();
        if (m_axis_tvalid && rdy) hs_cnt++;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; fv = 1'b0; fd = 16'd0; rdy = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        int t;
        t = 0;
        hs_cnt = 0;
        while (1) begin
            start = (t == 0) || (t == f.start2_t);
            fac   = (t == 0) ? f.fac : f.fac + 32'd100;
            len   = 16'(f.len);
            stop  = (t == f.stop_t);
            fv    = (t >= 3) && (((t - 3) % f.gap) == 0);
            fd    = 16'(10 * ((t - 3) / f.gap + 1));
            rdy   = (t - 3) >= f.rdy_low;
            cyc();
            t++;
            if (t > 3 && m_phase == 0) break;
            if (t > 400) begin
                n_vec++; n_bad++;
                $display("FAIL frame_timeout: got busy after %0d cycles expected idle", t);
                break;
            end
        end
        idle_inputs();
        chk("beats", 32'(hs_cnt), 32'(f.exp_beats));
        chk("overrun_final", 32'(overrun_cnt), 32'(f.exp_ovr));
    endtask

    initial begin
        //            fac    len gap rdy_low stop_t start2_t beats ovr
        tbl[0] = '{32'd3,  4,  4,  0, -1,  8,  4, 0};   // basic frame, start in capture ignored
        tbl[1] = '{32'd5,  8,  1,  5, -1, -1,  8, 4};   // backpressure
        tbl[2] = '{32'd11, 10, 2,  0,  6, -1,  3, 0};   // stop after 2 beats
        tbl[3] = '{32'd9,  1,  3,  0, -1, -1,  1, 0};   // single-beat frame
        tbl[4] = '{32'd7,  5,  1,  0,  1, -1,  0, 0};   // stop during flush
        tbl[5] = '{32'd2,  6,  1,  0, -1, -1,  6, 0};   // back-to-back samples

        rst = 1'b0; trig = 1'b0; fac = 32'd0; len = 16'd0;
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset_filt_rst_n", 32'(filt_rst_n), 32'd0);
        chk("reset_mavg", mavg_factor_out, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overrun", 32'(overrun_cnt), 32'd0);
        #3 rst = 1'b1;
        cyc();   // filt_rst_n rises on the first edge after release

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i]);
            cyc();
        end

        // start with zero length is ignored
        start = 1'b1; len = 16'd0; fac = 32'd55;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("len0_busy", 32'(busy), 32'd0);

        // start together with stop is ignored
        start = 1'b1; stop = 1'b1; len = 16'd4; fac = 32'd66;
        cyc();
        start = 1'b0; stop = 1'b0;
        cyc(); cyc();
        chk("startstop_busy", 32'(busy), 32'd0);

        // reset in the middle of a 6-beat frame
        hs_cnt = 0;
        start = 1'b1; len = 16'd6; fac = 32'd77; rdy = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 40 && hs_cnt < 3; k++) begin
            fv = 1'b1; fd = 16'(100 + k);
            cyc();
        end
        chk("pre_reset_beats", 32'(hs_cnt), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_mavg", mavg_factor_out, 32'd0);
        chk("async_filt_rst_n", 32'(filt_rst_n), 32'd0);
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        chk("in_reset_filt_rst_n", 32'(filt_rst_n), 32'd0);
        #2 rst = 1'b1;
        cyc();
        run_frame(tbl[5]);

        // randomized frames
        for (int r = 0; r < 25; r++) begin
            int t;
            t = 0;
            while (1) begin
                start = (t == 0) ? 1'b1 : ($urandom % 30 == 0);
                if (t == 0) begin
                    len = 16'($urandom_range(0, 12));
                    fac = $urandom;
                end
                stop = (t > 0) && ($urandom % 40 == 0);
                fv   = $urandom % 2;
                fd   = 16'($urandom);
                rdy  = ($urandom % 4) != 0;
                cyc();
                t++;
                if (t > 3 && m_phase == 0) break;
                if (t > 500) begin
                    n_vec++; n_bad++;
                    $display("FAIL random_timeout: got busy after %0d cycles expected idle", t);
                    break;
                end
            end
            idle_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
